muldiv_ctrl: RTL
================

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand and HI/LO width.
REQ-002 SHALL have port: clk  in  1  rising-edge clock.
REQ-003 SHALL have port: rst_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have port: start  in  1  request strobe, sampled on clk edge.
REQ-005 SHALL have port: op  in  3  operation code, encoded per package.
REQ-006 SHALL have port: a  in  WIDTH  rs operand (multiplicand/dividend).
REQ-007 SHALL have port: b  in  WIDTH  rt operand (multiplier/divisor).
REQ-008 SHALL have port: flush  in  1  cancel in-flight operation.
REQ-009 SHALL have port: busy  out  1  unit occupied; pipeline stalls on mfhi/mflo/new muldiv.
REQ-010 SHALL have port: done  out  1  one-cycle pulse when HI/LO updated by mult/div.
REQ-011 SHALL have port: hi  out  WIDTH  HI register.
REQ-012 SHALL have port: lo  out  WIDTH  LO register.

Function
REQ-013 SHALL use op codes: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 ignored.
REQ-014 SHALL implement FSM states IDLE, MUL, DIV, FIX.
REQ-015 SHALL accept start only in IDLE; start while busy=1 is ignored, no queueing.
REQ-016 SHALL, for MTHI/MTLO accepted in IDLE, write a into hi/lo at that edge; busy stays 0, done stays 0.
REQ-017 SHALL, for MULT/MULTU, latch operand magnitudes (signed ops: two's-complement abs) and enter MUL.
REQ-018 SHALL perform one shift-add step per cycle in MUL, exactly WIDTH cycles, 5-bit step counter 0..WIDTH-1, then enter FIX.
REQ-019 SHALL, for DIV/DIVU with b!=0, latch magnitudes and enter DIV: one restoring-division step per cycle, WIDTH cycles, then FIX.
REQ-020 SHALL, for DIV/DIVU with b==0, skip DIV: enter FIX directly with quotient = all ones, remainder = a (unsigned, no sign fix).
REQ-021 SHALL in FIX apply signs: product negated when sign(a)^sign(b) for MULT; quotient negated when sign(a)^sign(b), remainder takes sign(a) for DIV; unsigned ops unchanged.
REQ-022 SHALL write hi/lo at the FIX exit edge: mult hi={product[2W-1:W]}, lo={product[W-1:0]}; div lo=quotient, hi=remainder; done=1 for the following cycle; return to IDLE.
REQ-023 SHALL assert busy combinationally whenever state!=IDLE.
REQ-024 SHALL give latency: start at edge 0 -> busy from cycle 1 -> hi/lo valid and done=1 in cycle WIDTH+2 (34 for WIDTH=32); divide-by-zero: cycle 2.
REQ-025 SHALL, on flush (any state), return to IDLE next edge, leave hi/lo unchanged, no done; flush has priority over start in the same cycle.
REQ-026 SHALL treat most-negative operand (0x80000000) correctly; DIV 0x80000000 / -1 yields lo=0x80000000, hi=0.

Reset
REQ-027 SHALL on rst_n=0 immediately force state=IDLE, counter=0, hi=0, lo=0, busy=0, done=0, all datapath registers 0.
REQ-028 SHALL abandon any in-flight operation on reset mid-operation; no done after release.

Configuration
REQ-029 SHALL compile the divider only when MULDIV_DIVIDER_EN is defined.
REQ-030 SHALL, without MULDIV_DIVIDER_EN, treat DIV/DIVU as no-ops: no busy, no done, hi/lo unchanged; DIV state and divider registers absent.

Structure
REQ-031 SHALL place op-code constants, FSM state typedef and WIDTH default in shared package muldiv_pkg.
REQ-032 SHALL instantiate one sub-module muldiv_step (combinational single-step shift-add / restore-subtract), used by MUL and DIV states.

Verification
REQ-033 SHALL check MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> done at cycle 34, hi=0xFFFFFFFE, lo=0x00000001.
REQ-034 SHALL check MULT a=-3 b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high cycles 1..33.
REQ-035 SHALL check DIV a=-7 b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=100 b=0 -> hi=0x00000064, lo=0xFFFFFFFF, done at cycle 2.
REQ-036 SHALL check second start at cycle 5 during MULT ignored; flush at cycle 10 -> busy=0 cycle 11, hi/lo keep prior values, no done.
REQ-037 SHALL check MTHI a=0x12345678 in IDLE -> hi=0x12345678 next cycle, busy=0; rst_n low at cycle 15 of DIV -> hi=lo=0, busy=0 immediately.

Source files
------------

// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg -- shared definitions for the multiply/divide unit.
//   WIDTH_DEF : default operand / HI / LO width
//   op_e      : operation codes presented on muldiv_ctrl.op
//   state_e   : control FSM states (DIV exists only with MULDIV_DIVIDER_EN)
// Configuration macro: MULDIV_DIVIDER_EN (enables the divider).
// -----------------------------------------------------------------------------
package muldiv_pkg;

  localparam int WIDTH_DEF = 32;

  // 3'b110 and 3'b111 are reserved and ignored by the unit.
  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_FIX  = 2'd2
`ifdef MULDIV_DIVIDER_EN
    ,
    ST_DIV  = 2'd3
`endif
  } state_e;

  // Signed variants need magnitude conversion on entry and sign fix-up on exit.
  function automatic logic op_is_signed(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// -----------------------------------------------------------------------------
// muldiv_step -- one iteration of the iterative multiplier / divider (comb).
//   div_mode : 0 = shift-add multiply step, 1 = restoring divide step
//   acc_i    : upper half (partial product / partial remainder)
//   lsr_i    : lower half (multiplier bits / dividend-quotient bits)
//   opnd_i   : multiplicand or divisor magnitude
//   acc_o, lsr_o : updated halves after one step
// Multiply: {acc,lsr} <- ({acc + (lsr[0] ? opnd : 0), lsr} >> 1)
// Divide  : shift {acc,lsr} left by one, subtract opnd from the upper part,
//           keep the difference and shift in 1 if no borrow, else restore.
// -----------------------------------------------------------------------------
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             div_mode,
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] lsr_i,
  input  logic [WIDTH-1:0] opnd_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] lsr_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // NOTE: every signal assigned in an always_comb gets a value on every path
  // (defaults first or a full if/else), otherwise synthesis infers a latch.
  always_comb begin
    sum     = {1'b0, acc_i} + (lsr_i[0] ? {1'b0, opnd_i} : '0);
    shifted = {acc_i, lsr_i[WIDTH-1]};
    // Partial remainder is always < 2*opnd, so bit WIDTH of diff is exactly
    // the borrow of the trial subtraction.
    diff    = shifted - {1'b0, opnd_i};
    if (div_mode) begin
      if (!diff[WIDTH]) begin
        acc_o = diff[WIDTH-1:0];
        lsr_o = {lsr_i[WIDTH-2:0], 1'b1};
      end else begin
        acc_o = shifted[WIDTH-1:0];
        lsr_o = {lsr_i[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_o = sum[WIDTH:1];
      lsr_o = {sum[0], lsr_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// -----------------------------------------------------------------------------
// muldiv_ctrl -- iterative HI/LO multiply/divide unit (MIPS-style).
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   start, op  : request strobe and operation (muldiv_pkg::op_e), IDLE only
//   a, b       : rs / rt operands
//   flush      : abandon any in-flight operation, HI/LO untouched
//   busy       : unit occupied (state != IDLE)
//   done       : one-cycle pulse after HI/LO were written by mult/div
//   hi, lo     : architectural HI / LO registers
// Timing: start at edge 0 -> MUL/DIV for WIDTH cycles -> FIX -> HI/LO written
// at the FIX exit edge, done in cycle WIDTH+2. Divide by zero goes straight
// to FIX (done in cycle 2) with quotient all ones and remainder = a.
// Configuration macro: MULDIV_DIVIDER_EN -- when undefined, DIV/DIVU are
// ignored and no divider state or registers exist.
// -----------------------------------------------------------------------------
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;     // product high half / partial remainder
  logic [WIDTH-1:0] lsr_q, lsr_d;     // multiplier bits / dividend -> quotient
  logic [WIDTH-1:0] opnd_q, opnd_d;   // multiplicand / divisor magnitude
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             neg_res_q, neg_res_d;  // negate product / quotient in FIX
  logic             done_q, done_d;
`ifdef MULDIV_DIVIDER_EN
  logic             is_div_q, is_div_d;
  logic             neg_rem_q, neg_rem_d;  // remainder takes sign of a
`endif

  // Operand magnitudes; the most-negative value maps onto itself, which is
  // the correct unsigned magnitude 2^(WIDTH-1).
  logic             sgn_op, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             start_ok;
  logic             step_div;
  logic [WIDTH-1:0] step_acc, step_lsr;
  logic [2*WIDTH-1:0] prod_mag, prod_fix;

  assign sgn_op   = op_is_signed(op);
  assign a_neg    = sgn_op & a[WIDTH-1];
  assign b_neg    = sgn_op & b[WIDTH-1];
  assign a_mag    = a_neg ? -a : a;
  assign b_mag    = b_neg ? -b : b;
  assign start_ok = start & ~flush;   // flush wins over a same-cycle start

  assign prod_mag = {acc_q, lsr_q};
  assign prod_fix = neg_res_q ? -prod_mag : prod_mag;

`ifdef MULDIV_DIVIDER_EN
  assign step_div = (state_q == ST_DIV);
`else
  assign step_div = 1'b0;
`endif

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .div_mode (step_div),
    .acc_i    (acc_q),
    .lsr_i    (lsr_q),
    .opnd_i   (opnd_q),
    .acc_o    (step_acc),
    .lsr_o    (step_lsr)
  );

  // ---------------------------------------------------------------- state reg
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values of the others; blocking here would create order races.
  // NOTE: datapath registers are reset too (not just control), so HI/LO and
  // all intermediate values read as 0 straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      lsr_q     <= '0;
      opnd_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      neg_res_q <= 1'b0;
      done_q    <= 1'b0;
`ifdef MULDIV_DIVIDER_EN
      is_div_q  <= 1'b0;
      neg_rem_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      lsr_q     <= lsr_d;
      opnd_q    <= opnd_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      neg_res_q <= neg_res_d;
      done_q    <= done_d;
`ifdef MULDIV_DIVIDER_EN
      is_div_q  <= is_div_d;
      neg_rem_q <= neg_rem_d;
`endif
    end
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            case (op)
              OP_MULT, OP_MULTU: state_d = ST_MUL;
`ifdef MULDIV_DIVIDER_EN
              OP_DIV, OP_DIVU:   state_d = (b == '0) ? ST_FIX : ST_DIV;
`endif
              default:           state_d = ST_IDLE;
            endcase
          end
        end
        ST_MUL:  if (cnt_q == CNT_LAST) state_d = ST_FIX;
`ifdef MULDIV_DIVIDER_EN
        ST_DIV:  if (cnt_q == CNT_LAST) state_d = ST_FIX;
`endif
        ST_FIX:  state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // ------------------------------------------------------- datapath / outputs
  always_comb begin
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    lsr_d     = lsr_q;
    opnd_d    = opnd_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    neg_res_d = neg_res_q;
    done_d    = 1'b0;
`ifdef MULDIV_DIVIDER_EN
    is_div_d  = is_div_q;
    neg_rem_d = neg_rem_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              acc_d     = '0;
              lsr_d     = b_mag;
              opnd_d    = a_mag;
              neg_res_d = a_neg ^ b_neg;
              cnt_d     = '0;
`ifdef MULDIV_DIVIDER_EN
              is_div_d  = 1'b0;
              neg_rem_d = 1'b0;
`endif
            end
`ifdef MULDIV_DIVIDER_EN
            OP_DIV, OP_DIVU: begin
              is_div_d = 1'b1;
              cnt_d    = '0;
              if (b == '0) begin
                // Raw dividend as remainder, all-ones quotient, no sign fix.
                acc_d     = a;
                lsr_d     = '1;
                neg_res_d = 1'b0;
                neg_rem_d = 1'b0;
              end else begin
                acc_d     = '0;
                lsr_d     = a_mag;
                opnd_d    = b_mag;
                neg_res_d = a_neg ^ b_neg;
                neg_rem_d = a_neg;
              end
            end
`endif
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
`ifdef MULDIV_DIVIDER_EN
      ST_MUL, ST_DIV: begin
`else
      ST_MUL: begin
`endif
        acc_d = step_acc;
        lsr_d = step_lsr;
        cnt_d = cnt_q + 1'b1;
      end
      ST_FIX: begin
        if (!flush) begin
`ifdef MULDIV_DIVIDER_EN
          if (is_div_q) begin
            lo_d = neg_res_q ? -lsr_q : lsr_q;
            hi_d = neg_rem_q ? -acc_q : acc_q;
          end else
`endif
          begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
          done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy = (state_q != ST_IDLE);
  end

  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
